// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one decimal digit per clock, LSD first.
// Results are registered and only update on completion of an operation.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q, res_q, sum_q;
    logic            sub_q, carry_q, err_int_q, cout_q, err_q;
    logic [IdxW-1:0] idx_q;

    logic [3:0]   a_dig, b_dig, b_adj, dig;
    logic [4:0]   t;
    logic         c_next, bad;
    logic [W-1:0] res_next;

    // Operands shift right each cycle, so the current digit is always in the low nibble.
    always_comb begin
        a_dig  = a_q[3:0];
        b_dig  = b_q[3:0];
        b_adj  = sub_q ? (4'd9 - b_dig) : b_dig;
        t      = 5'(a_dig) + 5'(b_adj) + 5'(carry_q);
        dig    = t[3:0];
        c_next = 1'b0;
        if (t > 5'd9) begin
            dig    = 4'(t + 5'd6);
            c_next = 1'b1;
        end
        bad      = (a_dig > 4'd9) || (b_dig > 4'd9);
        res_next = (res_q >> 4) | (W'(dig) << (4 * (DIGITS - 1)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (idx_q == LastIdx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            err_int_q <= 1'b0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        sub_q     <= sub;
                        carry_q   <= sub | cin;
                        err_int_q <= 1'b0;
                        idx_q     <= '0;
                    end
                end
                StRun: begin
                    a_q       <= a_q >> 4;
                    b_q       <= b_q >> 4;
                    carry_q   <= c_next;
                    res_q     <= res_next;
                    err_int_q <= err_int_q | bad;
                    idx_q     <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        sum_q  <= res_next;
                        cout_q <= c_next;
                        err_q  <= err_int_q | bad;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: digit-rule reference model with a
// per-cycle compare, directed literal cases and randomized traffic.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_acc    = 0;

    // Reference model state: cycles elapsed since accepted start (0 = idle).
    int          cnt = 0;
    logic        e_done = 1'b0;
    logic [15:0] e_sum = '0;
    logic        e_cout = 1'b0;
    logic        e_err = 1'b0;
    logic [15:0] p_sum = '0;
    logic        p_cout = 1'b0;
    logic        p_err = 1'b0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic ms, input logic mc,
                                  output logic [15:0] s, output logic co, output logic er);
        int c, ai, bi, bp, t;
        s  = '0;
        er = 1'b0;
        c  = ms ? 1 : int'(mc);
        for (int i = 0; i < DIGITS; i++) begin
            ai = int'((ma >> (4 * i)) & 16'hF);
            bi = int'((mb >> (4 * i)) & 16'hF);
            bp = ms ? (9 - bi + 16) % 16 : bi;
            t  = ai + bp + c;
            if (t > 9) begin
                s[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                s[4*i +: 4] = 4'(t);
                c = 0;
            end
            if (ai > 9 || bi > 9) er = 1'b1;
        end
        co = (c == 1);
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (cnt != 0) n_acc--;
            cnt    = 0;
            e_done = 1'b0;
            e_sum  = '0;
            e_cout = 1'b0;
            e_err  = 1'b0;
        end else begin
            e_done = 1'b0;
            if (cnt == 0) begin
                if (start === 1'b1) begin
                    model(a, b, sub, cin, p_sum, p_cout, p_err);
                    n_acc++;
                    cnt = 1;
                end
            end else if (cnt == DIGITS) begin
                e_sum  = p_sum;
                e_cout = p_cout;
                e_err  = p_err;
                e_done = 1'b1;
                cnt++;
            end else if (cnt == DIGITS + 1) begin
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(cnt != 0));
        chk("done", 32'(done), 32'(e_done));
        chk("sum", 32'(sum), 32'(e_sum));
        chk("cout", 32'(cout), 32'(e_cout));
        chk("err", 32'(err), 32'(e_err));
        if (done) n_done++;
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                         input logic tc, input logic [15:0] xs, input logic xc,
                         input logic xe, input string nm);
        int n;
        bit seen;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        n = 1;
        seen = 0;
        while (!seen && n < 20) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk({nm, " latency"}, 32'(n), 32'd5);
        chk({nm, " sum"}, 32'(sum), 32'(xs));
        chk({nm, " cout"}, 32'(cout), 32'(xc));
        chk({nm, " err"}, 32'(err), 32'(xe));
        chk({nm, " model"}, 32'(e_sum), 32'(xs));
        @(negedge clk);
        chk({nm, " pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        #2 rst_n = 1'b1;

        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, "add1");
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add2");
        do_op(16'h0999, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, "add3");
        do_op(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0, "sub1");
        do_op(16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0, "sub2");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "sub3");
        do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, "inv");
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, "clr");

        // Start held through RUN/DONE: only one operation may be accepted.
        d0 = n_done;
        @(negedge clk);
        a = 16'h2222; b = 16'h3333; sub = 1'b0; cin = 1'b0; start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("spam dones", 32'(n_done - d0), 32'd1);
        chk("spam sum", 32'(sum), 32'h5555);

        // Reset mid-run aborts without a done pulse.
        d0 = n_done;
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort no done", 32'(n_done - d0), 32'd0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, "post");

        repeat (400) begin
            @(negedge clk);
            a     = rand_bcd();
            b     = rand_bcd();
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("done count", 32'(n_done), 32'(n_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, under a start/done handshake. Extends the single-digit combinational BCD adder to N digits, adds ten's-complement subtraction and invalid-digit detection, and registers all results. Sits between operand registers and the decimal display/ALU path in lab datapaths.

## Interface
- DIGITS, default 4: number of BCD digits per operand (>= 1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = A + B + cin; 1 = A - B (ten's complement); captured at start.
- cin  in  1  decimal carry-in, add mode only; ignored when sub = 1.
- a  in  4*DIGITS  operand A, digit i at bits [4i+3:4i].
- b  in  4*DIGITS  operand B, same packing.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when results become valid.
- sum  out  4*DIGITS  BCD result.
- cout  out  1  add: decimal carry out; sub: 1 = no borrow (A >= B).
- err  out  1  1 if any captured digit of a or b exceeded 9.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: start = 1 captures a, b, sub and cin into internal registers, clears the digit index and the internal err flag, then moves to RUN.
- Operand preparation at capture:
  - sub = 1: each B digit becomes (9 - b_i) mod 16 and the initial carry is 1.
  - sub = 0: B is unchanged and the initial carry is cin.
- RUN, one digit per cycle, index i = 0..DIGITS-1:
  - t = a_i + b'_i + c, computed 5 bits wide (range 0..31).
  - If t > 9: digit = (t + 6) mod 16 and c = 1.
  - Otherwise: digit = t and c = 0.
  - The digit is written to position i of an internal result register.
- err: set if a_i > 9 or b_i > 9 (raw captured values). It is sticky for the operation. Computation continues with the same formula.
- After digit DIGITS-1: sum <= internal result, cout <= final c, err <= internal err flag, done = 1, state -> DONE.
- DONE lasts one cycle, then IDLE.
- start in RUN or DONE is ignored and not queued.
- In IDLE, a new start is accepted on the first idle cycle.
- sum, cout and err change only on the RUN -> DONE transition. They hold the last result through the following IDLE/RUN until the next completion.

## Timing
- Reset (asynchronous, immediate): state IDLE, busy 0, done 0, sum 0, cout 0, err 0, internal registers 0.
- Start sampled at edge k:
  - busy = 1 from k.
  - Digit i is computed at edge k+1+i.
  - done = 1 and results are valid for the cycle after edge k+DIGITS.
  - busy drops after edge k+DIGITS+1.
- Latency start -> done: DIGITS+1 cycles. Back-to-back throughput: one operation per DIGITS+2 cycles.
- Inputs a, b, sub and cin may change freely after the start edge.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs cleared.
- DIGITS = 1: RUN lasts one cycle and done is asserted 2 cycles after start.

## Test plan
- DIGITS = 4; add 1234 + 5678, cin = 0 -> sum 0x6912, cout 0, err 0. done exactly 5 cycles after start and high for one cycle.
- Add 9999 + 0001 -> sum 0x0000, cout 1. Add 0999 + 0000 with cin = 1 -> sum 0x1000, cout 0.
- Sub:
  - 5000 - 1234 -> sum 0x3766, cout 1.
  - 1234 - 5000 -> sum 0x6234, cout 0.
  - 0000 - 0000 -> sum 0x0000, cout 1 (cin = 1 ignored).
- Invalid digits: a = 0x00A0, b = 0x0000 -> err 1, sum 0x0100, cout 0. The next valid operation clears err.
- start pulsed every cycle during RUN/DONE -> exactly one done per accepted start. Results are unchanged by the ignored starts.
- rst_n low mid-RUN -> busy, done, sum, cout, err all 0 immediately. No done pulse follows. A fresh start after release behaves normally.
